dmem_arbiter: RTL

Two-requester arbiter for the single-port data memory of the 16-bit single-cycle MIPS computer. It sits between the CPU datapath's load/store port and `dmem`, and shares the memory with a host port used for program loading, DMA and debug readback. The CPU has priority by default. A wait counter guarantees the host is served, and a burst limit bounds how long the CPU is stalled.

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter of the 16-bit MIPS
// computer: the arbiter state encoding and the default widths/limits that
// the computer top and the arbiter agree on.
//   DMEM_N        - data/address width of the CPU data port
//   DEF_WAIT_MAX  - cycles the host may be blocked before a forced grant
//   DEF_BURST_MAX - host accesses allowed per grant while the CPU waits
package dmem_arb_pkg;

  localparam int DMEM_N        = 16;
  localparam int DEF_WAIT_MAX  = 4;
  localparam int DEF_BURST_MAX = 8;

  // Memory port owner. S_CPU is the reset/default owner.
  typedef enum logic {
    S_CPU  = 1'b0,
    S_HOST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the three sides of the data-memory arbiter: the CPU load/store
// port, the host (loader/DMA/debug) port and the single dmem port.
//   slave  - seen by the arbiter: takes requests, drives acks/stall/memory
//   master - seen by the environment (CPU, host and dmem together)
interface dmem_arbiter_if import dmem_arb_pkg::*; #(
  parameter int N = DMEM_N
);

  logic         cpu_req;
  logic         cpu_we;
  logic [N-1:0] cpu_addr;
  logic [N-1:0] cpu_wdata;
  logic [N-1:0] cpu_rdata;
  logic         cpu_stall;

  logic         host_req;
  logic         host_we;
  logic [N-1:0] host_addr;
  logic [N-1:0] host_wdata;
  logic         host_ack;
  logic [N-1:0] host_rdata;

  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;

  logic         grant_host;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output grant_host
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  grant_host
  );

endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the CPU load/store port and
// the host port. The CPU owns the memory by default; a saturating wait
// counter forces a host grant after WAIT_MAX blocked cycles, and a
// saturating burst counter hands the port back to a waiting CPU after
// BURST_MAX host accesses.
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - dmem_arbiter_if.slave: CPU port, host port, dmem port, grant
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int N         = DMEM_N,
  parameter int WAIT_MAX  = DEF_WAIT_MAX,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);

  localparam int WAIT_W  = $clog2(WAIT_MAX + 1);
  localparam int BURST_W = $clog2(BURST_MAX + 1);

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(WAIT_MAX - 1);
  localparam logic [WAIT_W-1:0]  WAIT_TOP   = WAIT_W'(WAIT_MAX);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);
  localparam logic [BURST_W-1:0] BURST_TOP  = BURST_W'(BURST_MAX);

  arb_state_t         state_q, state_d;
  logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [BURST_W-1:0] burstCnt_q, burstCnt_d;
  logic [N-1:0]       hostRdata_q;

  logic hostOwn;
  logic hostAck;

  // Next-state logic. In S_CPU the wait counter measures how long the host
  // has been shut out by CPU traffic; it only runs while both sides want the
  // port. In S_HOST the burst counter only advances on accesses that actually
  // hold the CPU up, so an idle CPU lets the host stream indefinitely.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    burstCnt_d = burstCnt_q;
    case (state_q)
      S_CPU: begin
        burstCnt_d = '0;
        if (bus.host_req && (!bus.cpu_req || waitCnt_q == WAIT_LAST)) begin
          state_d   = S_HOST;
          waitCnt_d = '0;
        end else if (bus.host_req) begin
          if (waitCnt_q != WAIT_TOP) begin
            waitCnt_d = waitCnt_q + WAIT_W'(1);
          end
        end else begin
          waitCnt_d = '0;
        end
      end
      S_HOST: begin
        waitCnt_d = '0;
        if (bus.host_req && !(bus.cpu_req && burstCnt_q == BURST_LAST)) begin
          state_d = S_HOST;
          if (bus.cpu_req && burstCnt_q != BURST_TOP) begin
            burstCnt_d = burstCnt_q + BURST_W'(1);
          end
        end else begin
          state_d    = S_CPU;
          burstCnt_d = '0;
        end
      end
      default: begin
        state_d    = S_CPU;
        waitCnt_d  = '0;
        burstCnt_d = '0;
      end
    endcase
  end

  // Output muxes. Reset is folded into ownership so that during the reset
  // cycle the port falls back to the CPU fields with writes, acks and stalls
  // all suppressed, even when a host burst was in flight.
  always_comb begin
    hostOwn        = (state_q == S_HOST) && !reset;
    hostAck        = hostOwn && bus.host_req;
    bus.grant_host = hostOwn;
    bus.host_ack   = hostAck;
    bus.cpu_stall  = hostOwn && bus.cpu_req;
    bus.cpu_rdata  = bus.mem_rdata;
    bus.host_rdata = hostRdata_q;
    if (hostOwn) begin
      bus.mem_we    = bus.host_req && bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end else begin
      bus.mem_we    = bus.cpu_req && bus.cpu_we && !reset;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  // State, counters and the host read-data register. dmem reads are
  // combinational, so host read data is captured at the end of the ack
  // cycle and stays put until the next host read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CPU;
      waitCnt_q   <= '0;
      burstCnt_q  <= '0;
      hostRdata_q <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      burstCnt_q <= burstCnt_d;
      if (hostAck && !bus.host_we) begin
        hostRdata_q <= bus.mem_rdata;
      end
    end
  end

endmodule
